// File: rtl/picobello_pkg.sv
// Shared types and defaults for the wide AW injection shaper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package picobello_pkg;

    localparam int unsigned ShaperCntWidth       = 16;
    localparam int unsigned ShaperMaxOutstanding = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } shaper_state_e;

    // Config-register view of the shaper knobs.
    typedef struct packed {
        logic                      en;
        logic [ShaperCntWidth-1:0] refill_amt;
        logic [ShaperCntWidth-1:0] refill_period;
        logic [ShaperCntWidth-1:0] bucket_max;
    } shaper_cfg_t;

endpackage

// File: rtl/wide_inject_token_bucket.sv
// Token bucket: periodic refill counter plus saturating deduct/add/clamp token arithmetic.
// Latency: token count reflects a deduct or refill one cycle after the event.
// Backpressure: none; deduct requests are always absorbed (saturating at zero).
module wide_inject_token_bucket #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CntWidth-1:0] refill_amt_i,
    input  logic [CntWidth-1:0] refill_period_i,
    input  logic [CntWidth-1:0] bucket_max_i,
    input  logic                deduct_i,
    input  logic [8:0]          need_i,
    output logic [CntWidth-1:0] tokens_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] tokens_q, tokens_d;
    logic [CntWidth-1:0] period_m1;
    logic                refill_evt;
    logic [CntWidth:0]   tok_ext, need_ext, after_ded, after_add;

    // Refill timing and token update; one extra bit keeps the add from wrapping before the clamp.
    always_comb begin
        period_m1 = (refill_period_i == '0) ? '0 : refill_period_i - CntWidth'(1);
        // >= so that shrinking the period mid-count still wraps promptly
        refill_evt = (cnt_q >= period_m1);
        cnt_d      = refill_evt ? '0 : cnt_q + CntWidth'(1);

        tok_ext   = {1'b0, tokens_q};
        need_ext  = (CntWidth+1)'(need_i);
        after_ded = tok_ext;
        if (deduct_i) begin
            after_ded = (tok_ext >= need_ext) ? tok_ext - need_ext : '0;
        end
        after_add = after_ded;
        if (refill_evt) begin
            after_add = after_ded + {1'b0, refill_amt_i};
        end
        tokens_d = (after_add > {1'b0, bucket_max_i}) ? bucket_max_i : after_add[CntWidth-1:0];
    end

    // Counter and token state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            tokens_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            tokens_q <= tokens_d;
        end
    end

    assign tokens_o = tokens_q;

endmodule

// File: rtl/wide_inject_shaper.sv
// AW-channel token-bucket shaper for the wide injection port; optional stall counter under WIDE_INJECT_SHAPER_STATS_EN.
// Latency: input handshake at T gives out_aw_valid_o at T+2 at the earliest; one AW per 3 cycles peak.
// Backpressure: in_aw_ready_o only in IDLE; out_aw_valid_o held until out_aw_ready_i, never withdrawn.
module wide_inject_shaper
    import picobello_pkg::*;
#(
    parameter  int unsigned AwWidth        = 64,
    parameter  int unsigned CntWidth       = ShaperCntWidth,
    parameter  int unsigned MaxOutstanding = ShaperMaxOutstanding,
    localparam int unsigned OutW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [CntWidth-1:0] refill_amt_i,
    input  logic [CntWidth-1:0] refill_period_i,
    input  logic [CntWidth-1:0] bucket_max_i,
    input  logic                in_aw_valid_i,
    output logic                in_aw_ready_o,
    input  logic [7:0]          in_aw_len_i,
    input  logic [AwWidth-1:0]  in_aw_i,
    output logic                out_aw_valid_o,
    input  logic                out_aw_ready_i,
    output logic [AwWidth-1:0]  out_aw_o,
    input  logic                b_fire_i,
`ifdef WIDE_INJECT_SHAPER_STATS_EN
    output logic [31:0]         stall_cycles_o,
    input  logic                stats_clr_i,
`endif
    output logic [CntWidth-1:0] tokens_o,
    output logic [OutW-1:0]     outstanding_o
);

    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    shaper_state_e        state_q, state_d;
    logic [AwWidth-1:0]   aw_q, aw_d;
    logic [8:0]           need_q, need_d;
    logic                 in_aw_ready_q, in_aw_ready_d;
    logic                 out_aw_valid_q, out_aw_valid_d;
    logic [OutW-1:0]      outstanding_q, outstanding_d;
    logic                 out_fire, b_dec, eligible;
    logic [CntWidth-1:0]  tokens;

    wide_inject_token_bucket #(
        .CntWidth (CntWidth)
    ) u_bucket (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .refill_amt_i    (refill_amt_i),
        .refill_period_i (refill_period_i),
        .bucket_max_i    (bucket_max_i),
        .deduct_i        (out_fire & en_i),
        .need_i          (need_q),
        .tokens_o        (tokens)
    );

    // Next-state, payload latch, registered handshake outputs and outstanding tracking.
    always_comb begin
        state_d  = state_q;
        aw_d     = aw_q;
        need_d   = need_q;
        out_fire = out_aw_valid_q & out_aw_ready_i;
        // A B with nothing outstanding is a protocol error; ignore it rather than wrap.
        b_dec    = b_fire_i & (outstanding_q != '0);
        // tokens==max lets a burst larger than the whole bucket still go once the bucket is full
        eligible = !en_i || (((tokens >= CntWidth'(need_q)) || (tokens == bucket_max_i))
                             && (outstanding_q < MaxOut));

        unique case (state_q)
            IDLE: begin
                if (in_aw_valid_i) begin
                    aw_d    = in_aw_i;
                    need_d  = {1'b0, in_aw_len_i} + 9'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (eligible) state_d = ISSUE;
            end
            ISSUE: begin
                if (out_aw_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_aw_ready_d  = (state_d == IDLE);
        out_aw_valid_d = (state_d == ISSUE);

        outstanding_d = outstanding_q;
        if (out_fire && !b_dec) outstanding_d = outstanding_q + OutW'(1);
        else if (!out_fire && b_dec) outstanding_d = outstanding_q - OutW'(1);
    end

    // FSM, payload and counter state; reset drops any held AW.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            aw_q           <= '0;
            need_q         <= '0;
            in_aw_ready_q  <= 1'b1;
            out_aw_valid_q <= 1'b0;
            outstanding_q  <= '0;
        end else begin
            state_q        <= state_d;
            aw_q           <= aw_d;
            need_q         <= need_d;
            in_aw_ready_q  <= in_aw_ready_d;
            out_aw_valid_q <= out_aw_valid_d;
            outstanding_q  <= outstanding_d;
        end
    end

    b_without_outstanding_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(b_fire_i && (outstanding_q == '0)));

`ifdef WIDE_INJECT_SHAPER_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles parked in WAIT; clear has priority.
    always_comb begin
        stall_d = stall_q;
        if (stats_clr_i) stall_d = '0;
        else if ((state_q == WAIT) && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end

    // Stall counter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles_o = stall_q;
`endif

    assign in_aw_ready_o  = in_aw_ready_q;
    assign out_aw_valid_o = out_aw_valid_q;
    assign out_aw_o       = aw_q;
    assign tokens_o       = tokens;
    assign outstanding_o  = outstanding_q;

endmodule
